// File: rtl/dq_wr_serializer_if.sv
// Write-side bus for one DQ lane serializer: word push, slip request and the
// serial bit-pair outputs with FIFO status.
interface dq_wr_serializer_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  WR_EN;
  logic [3:0]            WR_DATA;
  logic                  WR_FULL;
  logic                  ALIGNWD;
  logic                  Q_P;
  logic                  Q_N;
  logic                  Q_VALID;
  logic [DEPTH_LOG2:0]   LEVEL;
  logic                  OVERFLOW;

  modport master (
    output WR_EN, WR_DATA, ALIGNWD,
    input  WR_FULL, Q_P, Q_N, Q_VALID, LEVEL, OVERFLOW
  );

  modport slave (
    input  WR_EN, WR_DATA, ALIGNWD,
    output WR_FULL, Q_P, Q_N, Q_VALID, LEVEL, OVERFLOW
  );
endinterface

// File: rtl/dq_wr_serializer.sv
// 4:2 write gearbox for one DQ lane: word FIFO, two-cycle bit-pair serializer,
// one-bit slip. Define DQ_WR_TRISTATE_EN to add the TQ output-enable port.
module dq_wr_serializer #(
  parameter int   DEPTH_LOG2 = 3,
  parameter logic IDLE_VAL   = 1'b0
) (
  input  logic                 SCLK,
  input  logic                 RSTN,
  dq_wr_serializer_if.slave    bus
`ifdef DQ_WR_TRISTATE_EN
  ,
  output logic                 TQ
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [3:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr, r_level;
  logic            r_full, r_ovf;
  logic            r_phase_p0;
  logic [1:0]      r_upper_p0;
  logic            r_sel, r_hold, r_align_p0;
  logic [1:0]      r_lock;
  logic            r_qp_p1, r_qn_p1, r_qv_p1;

  logic            w_empty, w_push, w_pop, w_rise;
  logic [PW-1:0]   w_wr_nxt, w_rd_nxt, w_lvl_nxt;
  logic [3:0]      w_head;
  logic            w_s0, w_s1, w_sv;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push    = bus.WR_EN & ~r_full;
  assign w_pop     = ~r_phase_p0 & ~w_empty;
  assign w_wr_nxt  = r_wr_ptr + PW'(w_push);
  assign w_rd_nxt  = r_rd_ptr + PW'(w_pop);
  assign w_lvl_nxt = w_wr_nxt - w_rd_nxt;
  assign w_head    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  // Slip requests are edge-detected and locked out for two cycles after a toggle.
  assign w_rise    = bus.ALIGNWD & ~r_align_p0 & (r_lock == 2'd0);

  always_comb begin
    w_s0 = IDLE_VAL;
    w_s1 = IDLE_VAL;
    w_sv = 1'b0;
    if (r_phase_p0) begin
      w_s0 = r_upper_p0[0];
      w_s1 = r_upper_p0[1];
      w_sv = 1'b1;
    end else if (!w_empty) begin
      w_s0 = w_head[0];
      w_s1 = w_head[1];
      w_sv = 1'b1;
    end
  end

  // Stage p0: FIFO storage and upper half of the word being serialized
  always_ff @(posedge SCLK) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= bus.WR_DATA;
    if (w_pop)  r_upper_p0 <= w_head[3:2];
  end

  always_ff @(posedge SCLK) begin
    if (!RSTN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_phase_p0 <= 1'b0;
      r_sel      <= 1'b0;
      r_hold     <= IDLE_VAL;
      r_align_p0 <= 1'b0;
      r_lock     <= 2'd0;
      r_qp_p1    <= IDLE_VAL;
      r_qn_p1    <= IDLE_VAL;
      r_qv_p1    <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_level    <= w_lvl_nxt;
      r_full     <= (w_lvl_nxt == PW'(DEPTH));
      r_ovf      <= r_ovf | (bus.WR_EN & r_full);
      r_phase_p0 <= r_phase_p0 ? 1'b0 : w_pop;
      r_align_p0 <= bus.ALIGNWD;
      if (w_rise) begin
        r_sel  <= ~r_sel;
        r_lock <= 2'd2;
      end else if (r_lock != 2'd0) begin
        r_lock <= r_lock - 2'd1;
      end
      // Stage p1: output pair, optionally delayed one bit through the hold register
      if (r_sel) begin
        r_qp_p1 <= r_hold;
        r_qn_p1 <= w_s0;
      end else begin
        r_qp_p1 <= w_s0;
        r_qn_p1 <= w_s1;
      end
      r_hold  <= w_s1;
      r_qv_p1 <= w_sv;
    end
  end

`ifdef DQ_WR_TRISTATE_EN
  logic r_tq_p1;
  // Drive while the next pair is valid or the current one was (one postamble cycle).
  always_ff @(posedge SCLK) begin
    if (!RSTN) r_tq_p1 <= 1'b1;
    else       r_tq_p1 <= ~(w_sv | r_qv_p1);
  end
  assign TQ = r_tq_p1;
`endif

  assign bus.WR_FULL  = r_full;
  assign bus.LEVEL    = r_level;
  assign bus.OVERFLOW = r_ovf;
  assign bus.Q_P      = r_qp_p1;
  assign bus.Q_N      = r_qn_p1;
  assign bus.Q_VALID  = r_qv_p1;
endmodule
